// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: sequential advance, stall hold,
// buffered redirect/trap. Optional macro PC_ALIGN_CHECK_EN turns misaligned redirects into traps.
//
// state | meaning
// BOOT  | out of reset, no fetch presented yet
// RUN   | presenting pc_out, nothing buffered
// PEND  | presenting pc_out, a redirect or trap is buffered
module pc_gen #(
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(32'h0000_0100),
  parameter int unsigned     INC       = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hazard_stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [PC_W-1:0] pc_out,
  output logic            redirect_taken,
  output logic            misalign_err
);

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

  state_t          state;
  logic            pend_trap;
  logic            pend_redir;
  logic [PC_W-1:0] pend_target;
  logic            misaligned;
  logic            req_trap;
  logic            req_redir;
  logic            adv;

`ifdef PC_ALIGN_CHECK_EN
  assign misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_err <= 1'b0;
    else        misalign_err <= misaligned;
  end
`else
  assign misaligned   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // A misaligned redirect is promoted to a trap and the redirect itself dropped.
  assign req_trap  = trap_valid || misaligned;
  assign req_redir = redirect_valid && !misaligned;
  assign adv       = fetch_ready && !hazard_stall && (state != BOOT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= BOOT;
      pc_out         <= RESET_VEC;
      fetch_valid    <= 1'b0;
      redirect_taken <= 1'b0;
      pend_trap      <= 1'b0;
      pend_redir     <= 1'b0;
      pend_target    <= '0;
    end else begin
      fetch_valid <= 1'b1;
      if (adv) begin
        if (req_trap || pend_trap) begin
          pc_out         <= TRAP_VEC;
          redirect_taken <= 1'b1;
        end else if (req_redir) begin
          pc_out         <= redirect_target;
          redirect_taken <= 1'b1;
        end else if (pend_redir) begin
          pc_out         <= pend_target;
          redirect_taken <= 1'b1;
        end else begin
          pc_out         <= pc_out + PC_W'(INC);
          redirect_taken <= 1'b0;
        end
        pend_trap  <= 1'b0;
        pend_redir <= 1'b0;
        state      <= RUN;
      end else begin
        redirect_taken <= 1'b0;
        if (req_trap) begin
          pend_trap  <= 1'b1;
          pend_redir <= 1'b0;
          state      <= PEND;
        end else if (req_redir && !pend_trap) begin
          pend_redir  <= 1'b1;
          pend_target <= redirect_target;
          state       <= PEND;
        end else if (state == BOOT) begin
          state <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: each scenario queues expected outputs as it drives
// a cycle and compares them once the DUT has clocked that cycle.
module tb_pc_gen;

  logic        clk;
  logic        rst_n;
  logic        hazard_stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] pc_out;
  logic        redirect_taken;
  logic        misalign_err;

  int checks   = 0;
  int failures = 0;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  typedef struct {
    logic        fr, hs, rv, tv;
    logic [31:0] rt;
    logic [31:0] pc;
    logic        tk, me;
  } step_t;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        tk, me;
  } exp_t;

  exp_t sb[$];

  pc_gen dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hazard_stall    (hazard_stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .fetch_ready     (fetch_ready),
    .fetch_valid     (fetch_valid),
    .pc_out          (pc_out),
    .redirect_taken  (redirect_taken),
    .misalign_err    (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic step_t mk(bit fr, bit hs, bit rv, logic [31:0] rt, bit tv,
                               logic [31:0] pc, bit tk, bit me);
    step_t s;
    s.fr = fr; s.hs = hs; s.rv = rv; s.rt = rt; s.tv = tv;
    s.pc = pc; s.tk = tk; s.me = me;
    return s;
  endfunction

  task automatic drive(input step_t s);
    fetch_ready     = s.fr;
    hazard_stall    = s.hs;
    redirect_valid  = s.rv;
    redirect_target = s.rt;
    trap_valid      = s.tv;
    sb.push_back('{1'b1, s.pc, s.tk, s.me});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fetch_ready = 1'b1; hazard_stall = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; trap_valid = 1'b0;
    #3;
    checks++;
    if ({fetch_valid, pc_out, redirect_taken, misalign_err} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset: got v=%0b pc=%h tk=%0b me=%0b, expected v=0 pc=00000000 tk=0 me=0",
               fetch_valid, pc_out, redirect_taken, misalign_err);
    end
    tick(); tick();
    checks++;
    if ({fetch_valid, pc_out} !== {1'b0, 32'h0}) begin
      failures++;
      $display("FAIL reset_held: got v=%0b pc=%h, expected v=0 pc=00000000", fetch_valid, pc_out);
    end
  endtask

  task automatic test_sequential();
    step_t st[$];
    exp_t  e;
    rst_n = 1'b1;
    st.push_back(mk(1, 0, 0, 0, 0, 32'h0, 0, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 32'h4, 0, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 32'h8, 0, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 32'hC, 0, 0));
    foreach (st[i]) begin
      drive(st[i]); tick(); e = sb.pop_front(); checks++;
      if ({fetch_valid, pc_out, redirect_taken, misalign_err} !== {e.v, e.pc, e.tk, e.me}) begin
        failures++;
        $display("FAIL sequential[%0d]: got v=%0b pc=%h tk=%0b me=%0b, expected v=%0b pc=%h tk=%0b me=%0b",
                 i, fetch_valid, pc_out, redirect_taken, misalign_err, e.v, e.pc, e.tk, e.me);
      end
    end
  endtask

  task automatic test_stall_hold();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(1, 1, 0, 0, 0, 32'hC, 0, 0));
    st.push_back(mk(1, 1, 0, 0, 0, 32'hC, 0, 0));
    st.push_back(mk(1, 1, 0, 0, 0, 32'hC, 0, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 32'h10, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 32'h10, 0, 0));
    foreach (st[i]) begin
      drive(st[i]); tick(); e = sb.pop_front(); checks++;
      if ({fetch_valid, pc_out, redirect_taken, misalign_err} !== {e.v, e.pc, e.tk, e.me}) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got v=%0b pc=%h tk=%0b me=%0b, expected v=%0b pc=%h tk=%0b me=%0b",
                 i, fetch_valid, pc_out, redirect_taken, misalign_err, e.v, e.pc, e.tk, e.me);
      end
    end
  endtask

  task automatic test_immediate_redirect();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(1, 0, 1, 32'h200, 0, 32'h200, 1, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 32'h204, 0, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 32'h208, 0, 0));
    foreach (st[i]) begin
      drive(st[i]); tick(); e = sb.pop_front(); checks++;
      if ({fetch_valid, pc_out, redirect_taken, misalign_err} !== {e.v, e.pc, e.tk, e.me}) begin
        failures++;
        $display("FAIL immediate_redirect[%0d]: got v=%0b pc=%h tk=%0b me=%0b, expected v=%0b pc=%h tk=%0b me=%0b",
                 i, fetch_valid, pc_out, redirect_taken, misalign_err, e.v, e.pc, e.tk, e.me);
      end
    end
  endtask

  task automatic test_buffered_redirect();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 0, 1, 32'h300, 0, 32'h208, 0, 0));
    st.push_back(mk(0, 0, 1, 32'h400, 0, 32'h208, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 32'h208, 0, 0));
    st.push_back(mk(1, 1, 0, 0, 0, 32'h208, 0, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 32'h400, 1, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 32'h404, 0, 0));
    foreach (st[i]) begin
      drive(st[i]); tick(); e = sb.pop_front(); checks++;
      if ({fetch_valid, pc_out, redirect_taken, misalign_err} !== {e.v, e.pc, e.tk, e.me}) begin
        failures++;
        $display("FAIL buffered_redirect[%0d]: got v=%0b pc=%h tk=%0b me=%0b, expected v=%0b pc=%h tk=%0b me=%0b",
                 i, fetch_valid, pc_out, redirect_taken, misalign_err, e.v, e.pc, e.tk, e.me);
      end
    end
  endtask

  task automatic test_trap_priority();
    step_t st[$];
    exp_t  e;
    // trap with simultaneous redirect, then a later redirect that must not displace it
    st.push_back(mk(0, 0, 1, 32'h500, 1, 32'h404, 0, 0));
    st.push_back(mk(0, 0, 1, 32'h600, 0, 32'h404, 0, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 32'h100, 1, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 32'h104, 0, 0));
    // newer same-cycle redirect beats a pending one
    st.push_back(mk(0, 0, 1, 32'h700, 0, 32'h104, 0, 0));
    st.push_back(mk(1, 0, 1, 32'h800, 0, 32'h800, 1, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 32'h804, 0, 0));
    st.push_back(mk(1, 0, 1, 32'h900, 1, 32'h100, 1, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 32'h104, 0, 0));
    // trap replaces a pending redirect
    st.push_back(mk(0, 0, 1, 32'hA00, 0, 32'h104, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 1, 32'h104, 0, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 32'h100, 1, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 32'h104, 0, 0));
    foreach (st[i]) begin
      drive(st[i]); tick(); e = sb.pop_front(); checks++;
      if ({fetch_valid, pc_out, redirect_taken, misalign_err} !== {e.v, e.pc, e.tk, e.me}) begin
        failures++;
        $display("FAIL trap_priority[%0d]: got v=%0b pc=%h tk=%0b me=%0b, expected v=%0b pc=%h tk=%0b me=%0b",
                 i, fetch_valid, pc_out, redirect_taken, misalign_err, e.v, e.pc, e.tk, e.me);
      end
    end
  endtask

  task automatic test_misalign();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(1, 0, 1, 32'h202, 0, ALN ? 32'h100 : 32'h202, 1, ALN));
    st.push_back(mk(1, 0, 0, 0, 0, ALN ? 32'h104 : 32'h206, 0, 0));
    st.push_back(mk(0, 0, 1, 32'h302, 0, ALN ? 32'h104 : 32'h206, 0, ALN));
    st.push_back(mk(1, 0, 0, 0, 0, ALN ? 32'h100 : 32'h302, 1, 0));
    st.push_back(mk(1, 0, 0, 0, 0, ALN ? 32'h104 : 32'h306, 0, 0));
    foreach (st[i]) begin
      drive(st[i]); tick(); e = sb.pop_front(); checks++;
      if ({fetch_valid, pc_out, redirect_taken, misalign_err} !== {e.v, e.pc, e.tk, e.me}) begin
        failures++;
        $display("FAIL misalign[%0d]: got v=%0b pc=%h tk=%0b me=%0b, expected v=%0b pc=%h tk=%0b me=%0b",
                 i, fetch_valid, pc_out, redirect_taken, misalign_err, e.v, e.pc, e.tk, e.me);
      end
    end
  endtask

  task automatic test_wrap();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(1, 0, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 32'h0, 0, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 32'h4, 0, 0));
    foreach (st[i]) begin
      drive(st[i]); tick(); e = sb.pop_front(); checks++;
      if ({fetch_valid, pc_out, redirect_taken, misalign_err} !== {e.v, e.pc, e.tk, e.me}) begin
        failures++;
        $display("FAIL wrap[%0d]: got v=%0b pc=%h tk=%0b me=%0b, expected v=%0b pc=%h tk=%0b me=%0b",
                 i, fetch_valid, pc_out, redirect_taken, misalign_err, e.v, e.pc, e.tk, e.me);
      end
    end
  endtask

  task automatic test_reset_in_pend();
    step_t st[$];
    exp_t  e;
    drive(mk(0, 0, 1, 32'h40, 0, 32'h4, 0, 0));
    tick(); e = sb.pop_front(); checks++;
    if ({fetch_valid, pc_out, redirect_taken} !== {e.v, e.pc, e.tk}) begin
      failures++;
      $display("FAIL pend_capture: got v=%0b pc=%h tk=%0b, expected v=%0b pc=%h tk=%0b",
               fetch_valid, pc_out, redirect_taken, e.v, e.pc, e.tk);
    end
    redirect_valid = 1'b0;
    fetch_ready    = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({fetch_valid, pc_out, redirect_taken, misalign_err} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset: got v=%0b pc=%h tk=%0b me=%0b, expected v=0 pc=00000000 tk=0 me=0",
               fetch_valid, pc_out, redirect_taken, misalign_err);
    end
    tick();
    rst_n = 1'b1;
    st.push_back(mk(1, 0, 0, 0, 0, 32'h0, 0, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 32'h4, 0, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 32'h8, 0, 0));
    foreach (st[i]) begin
      drive(st[i]); tick(); e = sb.pop_front(); checks++;
      if ({fetch_valid, pc_out, redirect_taken, misalign_err} !== {e.v, e.pc, e.tk, e.me}) begin
        failures++;
        $display("FAIL reset_in_pend[%0d]: got v=%0b pc=%h tk=%0b me=%0b, expected v=%0b pc=%h tk=%0b me=%0b",
                 i, fetch_valid, pc_out, redirect_taken, misalign_err, e.v, e.pc, e.tk, e.me);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_hold();
    test_immediate_redirect();
    test_buffered_redirect();
    test_trap_priority();
    test_misalign();
    test_wrap();
    test_reset_in_pend();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
